// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong game-flow sequencer.
//   - 3-bit state encodings, as seen by the overlay on state_out
//   - score width and default timing constants
//   - sat_inc: saturating score increment
package pong_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SCORE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_SERVE     = 3'd1;
  localparam logic [STATE_W-1:0] S_PLAY      = 3'd2;
  localparam logic [STATE_W-1:0] S_PAUSE     = 3'd3;
  localparam logic [STATE_W-1:0] S_POINT     = 3'd4;
  localparam logic [STATE_W-1:0] S_GAME_OVER = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = S_IDLE,
    SERVE     = S_SERVE,
    PLAY      = S_PLAY,
    PAUSE     = S_PAUSE,
    POINT     = S_POINT,
    GAME_OVER = S_GAME_OVER
  } state_e;

  localparam int unsigned DEF_WIN_SCORE    = 9;
  localparam int unsigned DEF_SERVE_FRAMES = 60;
  localparam int unsigned DEF_POINT_FRAMES = 90;
  localparam int unsigned DEF_TIMER_W      = 8;

  // Scores stop at all-ones instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: frame-count down-timer used for the serve and point waits.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load_i       load load_val_i (takes priority over counting)
//   load_val_i   value to load, N-1 for a wait of N frames
//   tick_i       one-cycle frame pulse; the count moves only on these
//   expire_o     combinational pulse: tick_i seen while the count is zero
module pong_frame_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // The tick that finds the count at zero is the last tick of the wait.
  assign expire_o = tick_i && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_game_ctl.sv
// pong_game_ctl: game-flow sequencer for the Pong datapath (pixel clock domain).
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   frame_tick             one-cycle pulse per frame
//   button, mouse_left     start/pause sources, already in the clk domain
//   miss_l, miss_r         one-cycle pulses: ball passed left/right paddle
//   ball_run               ball datapath may advance on frame_tick
//   ball_reset             one-cycle pulse: re-centre ball, load serve_dir
//   serve_dir              0 = serve left, 1 = serve right
//   score_l, score_r       binary player scores
//   game_over, winner      game finished / who won (1 = right)
//   state_out              current state encoding for the overlay
// All outputs are registered.
module pong_game_ctl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int unsigned TIMER_W      = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               button,
  input  logic               mouse_left,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [STATE_W-1:0] state_out
);

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES - 1);

  state_e             state_q, state_d;
  logic               start_src_q;
  logic               ball_run_q, ball_run_d;
  logic               ball_reset_q, ball_reset_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  logic               start;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expire;
  logic [SCORE_W-1:0] inc_l;
  logic [SCORE_W-1:0] inc_r;

  // Either source starts/pauses; only the rising edge counts, so a held
  // button gives exactly one toggle.
  assign start = (button || mouse_left) && !start_src_q;

  // Incremented scores feed both the score registers and the win check,
  // so the game-over decision never sees a stale score.
  assign inc_l = sat_inc(score_l_q);
  assign inc_r = sat_inc(score_r_q);

  pong_frame_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (frame_tick),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = SERVE_LOAD;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          score_l_d    = '0;
          score_r_d    = '0;
          winner_d     = 1'b0;
          serve_dir_d  = 1'b1;
          ball_reset_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = SERVE_LOAD;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        if (tmr_expire) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        // A miss outranks start in the same cycle.
        if (miss_l && miss_r) begin
          tmr_load = 1'b1;
          tmr_val  = POINT_LOAD;
          state_d  = POINT;
        end else if (miss_l) begin
          score_r_d = inc_r;
          if (inc_r == WIN_VAL) begin
            winner_d = 1'b1;
            state_d  = GAME_OVER;
          end else begin
            serve_dir_d = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = POINT_LOAD;
            state_d     = POINT;
          end
        end else if (miss_r) begin
          score_l_d = inc_l;
          if (inc_l == WIN_VAL) begin
            winner_d = 1'b0;
            state_d  = GAME_OVER;
          end else begin
            serve_dir_d = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = POINT_LOAD;
            state_d     = POINT;
          end
        end else if (start) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start) begin
          state_d = PLAY;
        end
      end
      POINT: begin
        if (tmr_expire) begin
          ball_reset_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = SERVE_LOAD;
          state_d      = SERVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Decoded from the next state so ball_run falls in the very cycle the
    // state leaves PLAY, blocking any advance on the following frame_tick.
    ball_run_d  = (state_d == PLAY);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_src_q  <= 1'b0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_src_q  <= button || mouse_left;
      ball_run_q   <= ball_run_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_pong_game_ctl.sv
// tb_pong_game_ctl: directed-vector bench for pong_game_ctl with default
// parameters (WIN_SCORE 9, SERVE_FRAMES 60, POINT_FRAMES 90).
module tb_pong_game_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       button = 1'b0;
  logic       mouse_left = 1'b0;
  logic       miss_l = 1'b0;
  logic       miss_r = 1'b0;
  logic       ball_run;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;
  logic [2:0] state_out;

  int n_vec = 0;
  int n_bad = 0;

  pong_game_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .button     (button),
    .mouse_left (mouse_left),
    .miss_l     (miss_l),
    .miss_r     (miss_r),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .winner     (winner),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs set before the call are seen at the edge, outputs
  // are sampled 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick_once();
      cycle();
      cycle();
    end
  endtask

  task automatic press_button();
    button = 1'b1;
    cycle();
    button = 1'b0;
    cycle();
  endtask

  task automatic press_mouse();
    mouse_left = 1'b1;
    cycle();
    mouse_left = 1'b0;
    cycle();
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    miss_l = l;
    miss_r = r;
    cycle();
    miss_l = 1'b0;
    miss_r = 1'b0;
  endtask

  // POINT wait followed by SERVE wait, back in PLAY afterwards.
  task automatic point_serve();
    frames(90);
    frames(60);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    // Reset and idle.
    cycle();
    cycle();
    check("rst_state", state_out, 0);
    check("rst_run", ball_run, 0);
    check("rst_scores", {score_l, score_r}, 0);
    check("rst_ball_reset", ball_reset, 0);
    rst = 1'b0;
    frames(10);
    check("idle_state", state_out, 0);
    check("idle_run", ball_run, 0);
    check("idle_ball_reset", ball_reset, 0);

    // Start: one-cycle ball_reset, serve right, SERVE.
    button = 1'b1;
    cycle();
    button = 1'b0;
    check("start_state", state_out, 1);
    check("start_ball_reset", ball_reset, 1);
    check("start_serve_dir", serve_dir, 1);
    cycle();
    check("start_ball_reset_drop", ball_reset, 0);
    frames(59);
    check("serve_59_state", state_out, 1);
    check("serve_59_run", ball_run, 0);
    frames(1);
    check("serve_60_state", state_out, 2);
    check("serve_60_run", ball_run, 1);

    // miss_r scores for left.
    pulse_miss(1'b0, 1'b1);
    check("missr_score_l", score_l, 1);
    check("missr_run", ball_run, 0);
    check("missr_state", state_out, 4);
    check("missr_serve_dir", serve_dir, 1);
    frames(89);
    check("point_89_state", state_out, 4);
    check("point_89_ball_reset", ball_reset, 0);
    tick_once();
    check("point_90_state", state_out, 1);
    check("point_90_ball_reset", ball_reset, 1);
    cycle();
    check("point_90_ball_reset_drop", ball_reset, 0);
    frames(60);
    check("replay_state", state_out, 2);
    check("replay_serve_dir", serve_dir, 1);

    // Right player wins with nine misses on the left.
    for (int i = 1; i <= 8; i++) begin
      pulse_miss(1'b1, 1'b0);
      check("missl_score_r", score_r, 8'(i));
      check("missl_state", state_out, 4);
      check("missl_serve_dir", serve_dir, 0);
      point_serve();
    end
    pulse_miss(1'b1, 1'b0);
    check("win_score_r", score_r, 9);
    check("win_score_l", score_l, 1);
    check("win_game_over", game_over, 1);
    check("win_winner", winner, 1);
    check("win_state", state_out, 5);
    check("win_run", ball_run, 0);
    frames(3);
    check("over_hold_state", state_out, 5);
    check("over_hold_score_r", score_r, 9);
    press_button();
    check("restart_scores", {score_l, score_r}, 0);
    check("restart_state", state_out, 1);
    check("restart_game_over", game_over, 0);
    check("restart_winner", winner, 0);
    frames(60);
    check("restart_play", state_out, 2);

    // Pause and resume.
    press_mouse();
    check("pause_state", state_out, 3);
    check("pause_run", ball_run, 0);
    pulse_miss(1'b1, 1'b0);
    frames(2);
    check("pause_miss_state", state_out, 3);
    check("pause_miss_score_r", score_r, 0);
    press_mouse();
    check("resume_state", state_out, 2);
    check("resume_run", ball_run, 1);
    button = 1'b1;
    repeat (8) cycle();
    check("held_button_state", state_out, 3);
    button = 1'b0;
    cycle();
    check("held_release_state", state_out, 3);
    press_button();
    check("held_resume_state", state_out, 2);

    // Simultaneous misses: replay, no score.
    pulse_miss(1'b1, 1'b1);
    check("double_scores", {score_l, score_r}, 0);
    check("double_state", state_out, 4);
    check("double_run", ball_run, 0);
    point_serve();
    check("double_replay", state_out, 2);

    // Start together with a miss: the miss wins.
    button = 1'b1;
    pulse_miss(1'b0, 1'b1);
    button = 1'b0;
    check("startmiss_state", state_out, 4);
    check("startmiss_score_l", score_l, 1);
    point_serve();
    for (int i = 2; i <= 4; i++) begin
      pulse_miss(1'b0, 1'b1);
      point_serve();
    end
    pulse_miss(1'b0, 1'b1);
    check("five_score_l", score_l, 5);
    check("five_state", state_out, 4);
    frames(3);

    // Reset mid-POINT.
    rst = 1'b1;
    cycle();
    check("midrst_state", state_out, 0);
    check("midrst_scores", {score_l, score_r}, 0);
    check("midrst_flags", {ball_run, ball_reset, serve_dir, game_over, winner}, 0);
    rst = 1'b0;
    frames(2);
    check("midrst_idle", state_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctl.md
Name: pong_game_ctl

Overview:
Game-flow sequencer for the Pong datapath. It runs in the pixel clock domain, beside the drawing and control logic.
- Turns the start button, the left mouse button, per-frame ticks and ball-miss events into game states.
- Drives ball-motion enable, ball re-centre and serve direction toward the ball datapath.
- Keeps both player scores and presents them to the 7-segment driver and the overlay.

Parameters:
WIN_SCORE, 9, score that ends the game (1..15)
SERVE_FRAMES, 60, frames the ball is held still before each serve (1..255)
POINT_FRAMES, 90, frames of pause after a point before re-centring (1..255)
TIMER_W, 8, width of the frame timer

Ports:
clk  in  1  pixel clock (65 MHz)
rst  in  1  synchronous reset, active-high
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
button  in  1  board start/pause button, already synchronised to clk
mouse_left  in  1  delayed mouse left button, already in clk domain
miss_l  in  1  one-cycle pulse: ball passed the left paddle
miss_r  in  1  one-cycle pulse: ball passed the right paddle
ball_run  out  1  ball datapath may advance position on frame_tick
ball_reset  out  1  one-cycle pulse: re-centre the ball and load serve_dir
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
score_l  out  4  left player score, binary
score_r  out  4  right player score, binary
game_over  out  1  high while in GAME_OVER
winner  out  1  0 = left won, 1 = right won; valid while game_over
state_out  out  3  current state encoding, for the overlay

Behaviour:
- All outputs are registered. Reset values: state IDLE, all outputs 0, timer 0.
- start = rising edge of (button OR mouse_left), from a one-cycle-delayed copy. It is a one-clk pulse.
- The timer loads N-1 and decrements only on frame_tick. It expires on the frame_tick seen while timer == 0, so a wait lasts exactly N ticks.
- IDLE: ball_run = 0. On start:
  - score_l and score_r clear to 0, winner clears to 0.
  - serve_dir = 1; ball_reset pulses on the next cycle.
  - Timer loads SERVE_FRAMES-1; go to SERVE.
- SERVE: ball_run = 0. On timer expiry, go to PLAY. start is ignored in SERVE.
- PLAY: ball_run = 1.
  - miss_l alone: score_r += 1. miss_r alone: score_l += 1.
  - miss_l and miss_r in the same cycle: no score change; treat as a replay and go to POINT.
  - After a score, the registered score must equal WIN_SCORE on the next cycle for the GAME_OVER check. Use the incremented value, not a stale one.
  - If the new score equals WIN_SCORE: winner = scorer; go to GAME_OVER.
  - Otherwise: serve_dir is set toward the player who conceded (miss_l gives 0, miss_r gives 1). Timer loads POINT_FRAMES-1; go to POINT.
  - start with no miss: go to PAUSE.
  - start and a miss in the same cycle: the miss wins and start is dropped.
- PAUSE: ball_run = 0. miss_l, miss_r and frame_tick have no effect. start returns to PLAY.
- POINT: ball_run = 0. On expiry: ball_reset pulses for one cycle, timer loads SERVE_FRAMES-1, go to SERVE.
- GAME_OVER: ball_run = 0, game_over = 1, scores held. start does the same as start in IDLE.
- ball_run drops in the same cycle that state leaves PLAY. The datapath therefore never advances on the frame_tick that follows a miss.
- Scores saturate at 15. They cannot wrap, because WIN_SCORE ≤ 15 ends the game first.
- rst mid-game returns everything to reset values on the next clk edge, whatever the state or timer.
- state_out encoding: IDLE 0, SERVE 1, PLAY 2, PAUSE 3, POINT 4, GAME_OVER 5. Values 6 and 7 fall back to IDLE.

Decomposition:
- pong_pkg holds:
  - state encodings (localparams, 3 bit)
  - SCORE_W = 4
  - default timing constants
- One sub-module, pong_frame_timer: load/decrement on tick, expire pulse, TIMER_W wide. It is used for both the SERVE and POINT waits.
- The edge detect and the FSM stay in pong_game_ctl.

Test Plan:
- rst for 2 clk, then idle 10 frames → state_out = 0, ball_run = 0, scores 0/0, no ball_reset.
- button pulse in IDLE → ball_reset high exactly 1 clk, serve_dir = 1, state 1. After 60 frame_ticks (SERVE_FRAMES = 60) → state 2, ball_run = 1.
- In PLAY, miss_r pulse → score_l = 1, ball_run = 0 the same cycle. ball_reset comes after 90 ticks, then PLAY again after 60 more. Check serve_dir = 1.
- In PLAY, drive miss_l 9 times with full serve/point waits → score_r = 9, game_over = 1, winner = 1, state 5. button then → scores 0/0, state 1.
- In PLAY, mouse_left edge → state 3. miss_l pulse → no change. A second mouse_left edge → state 2. button held high → a single pause toggle only.
- miss_l and miss_r in the same cycle → scores unchanged, state 4. Also, with score_l = 5 in POINT, assert rst → all outputs 0 and state 0 on the next edge.
